// File: rtl/ncl_counter_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ncl_seq_pkg
// Shared definitions for the NCL counter-ring sequencer:
//   - seq_state_e : controller FSM states
//   - DR_*        : dual-rail digit encodings (rail1 = bit 1, rail0 = bit 0)
//   - dr_is_data / dr_is_illegal : digit classification helpers
// ----------------------------------------------------------------------------
package ncl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_DATA = 3'd1,
        ST_ISSUE_NULL = 3'd2,
        ST_WAIT_SUM   = 3'd3,
        ST_FAULT      = 3'd4
    } seq_state_e;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;

    // A digit carries DATA when exactly one rail is high.
    function automatic logic dr_is_data(input logic [1:0] d);
        return (d == DR_ZERO) || (d == DR_ONE);
    endfunction

    // Both rails high can never be produced by a healthy ring.
    function automatic logic dr_is_illegal(input logic [1:0] d);
        return (d == 2'b11);
    endfunction

endpackage

// File: rtl/ncl_counter_sequencer_if.sv
// ----------------------------------------------------------------------------
// ncl_counter_sequencer_if
// Groups the control bus and the ring-facing signals of the sequencer.
//   slave  : sequencer side (consumes start/steps and the ring's async
//            completions, drives status, cin_d and sum_comp)
//   master : environment side (host + ring)
// ----------------------------------------------------------------------------
interface ncl_counter_sequencer_if #(
    parameter int N_DIGITS = 32,
    parameter int STEP_W   = 16
);
    logic                    start;
    logic [STEP_W-1:0]       steps;
    logic                    busy;
    logic                    done;
    logic [1:0]              cin_d;
    logic                    cin_comp;
    logic [2*N_DIGITS-1:0]   sum_d;
    logic [N_DIGITS-1:0]     sum_comp;
    logic [N_DIGITS-1:0]     value;
    logic                    value_valid;
    logic                    timeout;
    logic                    rail_err;

    modport master (
        output start, steps, cin_comp, sum_d,
        input  busy, done, cin_d, sum_comp, value, value_valid, timeout, rail_err
    );

    modport slave (
        input  start, steps, cin_comp, sum_d,
        output busy, done, cin_d, sum_comp, value, value_valid, timeout, rail_err
    );
endinterface

// File: rtl/ncl_counter_sequencer_sync.sv
// ----------------------------------------------------------------------------
// ncl_sync
// STAGES-deep flip-flop synchronizer for WIDTH asynchronous bits. Each bit
// is synchronized independently; multi-bit coherence is handled by the
// consumer (dual-rail digits are monotonic between NULL and DATA).
// Ports: clk, init (sync active-high clear), i_d (async in), o_q (sync out)
// ----------------------------------------------------------------------------
module ncl_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift chain; first stage samples the asynchronous input.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/ncl_counter_sequencer.sv
// ----------------------------------------------------------------------------
// ncl_counter_sequencer
// Drives an N_DIGITS dual-rail NCL counter ring from synchronous logic:
// issues `steps` carry-in DATA/NULL wavefronts, consumes each sum wavefront
// through per-digit completion acks, reports each completed count as a
// single-rail value, and faults on a stalled ring or an illegal digit.
// Ports:
//   clk  - single clock
//   init - synchronous active-high reset (also the ring's init)
//   bus  - slave modport: start/steps/busy/done, cin_d/cin_comp,
//          sum_d/sum_comp, value/value_valid, timeout/rail_err
// ----------------------------------------------------------------------------
module ncl_counter_sequencer
    import ncl_seq_pkg::*;
#(
    parameter int N_DIGITS    = 32,
    parameter int STEP_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                     clk,
    input  logic                     init,
    ncl_counter_sequencer_if.slave   bus
);
    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [STEP_W-1:0] REM_ONE  = STEP_W'(1);

    // synchronized ring inputs
    logic                  w_cin_comp_s;
    logic [2*N_DIGITS-1:0] w_sum_s;

    // digit classification
    logic [N_DIGITS-1:0]   w_dig_data;
    logic [N_DIGITS-1:0]   w_dig_null;
    logic [N_DIGITS-1:0]   w_dig_ill;
    logic [N_DIGITS-1:0]   w_rail1;
    logic                  w_all_data;
    logic                  w_all_null;
    logic                  w_any_ill;

    // FSM / datapath
    seq_state_e            r_state;
    seq_state_e            w_next_state;
    logic [STEP_W-1:0]     r_remaining;
    logic [WD_W-1:0]       r_wdog;
    logic                  w_active;
    logic                  w_wd_expire;
    logic                  w_load;
    logic                  w_dec;
    logic                  w_done_set;
    logic                  w_to_set;
    logic                  w_re_set;
    logic                  w_capture;
    logic                  w_rearm;

    // registered outputs and collector state
    logic [1:0]            r_cin_d;
    logic [N_DIGITS-1:0]   r_sum_comp;
    logic                  r_busy;
    logic                  r_done;
    logic [N_DIGITS-1:0]   r_value;
    logic                  r_value_valid;
    logic                  r_timeout;
    logic                  r_rail_err;
    logic                  r_armed;
    logic                  r_wave_done;

    ncl_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_cin (
        .clk  (clk),
        .init (init),
        .i_d  (bus.cin_comp),
        .o_q  (w_cin_comp_s)
    );

    ncl_sync #(.WIDTH(2*N_DIGITS), .STAGES(SYNC_STAGES)) u_sync_sum (
        .clk  (clk),
        .init (init),
        .i_d  (bus.sum_d),
        .o_q  (w_sum_s)
    );

    // Classify every synchronized digit as NULL, DATA or illegal.
    always_comb begin
        w_dig_data = '0;
        w_dig_null = '0;
        w_dig_ill  = '0;
        w_rail1    = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            w_dig_data[k] = dr_is_data(w_sum_s[2*k +: 2]);
            w_dig_ill[k]  = dr_is_illegal(w_sum_s[2*k +: 2]);
            w_dig_null[k] = (w_sum_s[2*k +: 2] == DR_NULL);
            w_rail1[k]    = w_sum_s[2*k+1];
        end
    end

    assign w_all_data = &w_dig_data;
    assign w_all_null = &w_dig_null;
    assign w_any_ill  = |w_dig_ill;

    assign w_active = (r_state == ST_ISSUE_DATA) || (r_state == ST_ISSUE_NULL) ||
                      (r_state == ST_WAIT_SUM);

    // Capture once per wave: the last digit's ack is still low on the first
    // all-DATA cycle, and r_armed blocks repeats until the wave returns NULL.
    assign w_capture = r_armed && w_all_data && !(&r_sum_comp);
    assign w_rearm   = !r_armed && w_all_null;

    // Next-state and event decode; fault causes override the normal path.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_done_set   = 1'b0;
        w_to_set     = 1'b0;
        w_re_set     = 1'b0;
        w_wd_expire  = w_active && (r_wdog == WD_LIMIT);
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.steps != '0) begin
                        w_load       = 1'b1;
                        w_next_state = ST_ISSUE_DATA;
                    end else begin
                        w_done_set   = 1'b1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE_DATA: begin
                if (w_cin_comp_s) begin
                    w_next_state = ST_ISSUE_NULL;
                end else begin
                    w_next_state = ST_ISSUE_DATA;
                end
            end
            ST_ISSUE_NULL: begin
                if (!w_cin_comp_s) begin
                    w_next_state = ST_WAIT_SUM;
                end else begin
                    w_next_state = ST_ISSUE_NULL;
                end
            end
            ST_WAIT_SUM: begin
                if (r_wave_done || w_rearm) begin
                    w_dec = 1'b1;
                    if (r_remaining == REM_ONE) begin
                        w_done_set   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_ISSUE_DATA;
                    end
                end else begin
                    w_next_state = ST_WAIT_SUM;
                end
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_FAULT;
            end
        endcase

        if (w_wd_expire) begin
            w_to_set     = 1'b1;
            w_next_state = ST_FAULT;
        end else begin
            w_to_set     = 1'b0;
        end

        if (w_any_ill && (r_state != ST_FAULT)) begin
            w_re_set     = 1'b1;
            w_next_state = ST_FAULT;
        end else begin
            w_re_set     = 1'b0;
        end

        if (w_next_state == ST_FAULT) begin
            w_done_set = 1'b0;
        end else begin
            w_done_set = w_done_set;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remaining-increment counter.
    always_ff @(posedge clk) begin
        if (init) begin
            r_remaining <= '0;
        end else if (w_load) begin
            r_remaining <= bus.steps;
        end else if (w_dec) begin
            r_remaining <= r_remaining - REM_ONE;
        end else begin
            r_remaining <= r_remaining;
        end
    end

    // Watchdog: cycles spent in the current wait state.
    always_ff @(posedge clk) begin
        if (init) begin
            r_wdog <= '0;
        end else if (!w_active || (w_next_state != r_state)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    // Registered control outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (init) begin
            r_cin_d <= DR_NULL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cin_d <= (w_next_state == ST_ISSUE_DATA) ? DR_ONE : DR_NULL;
            r_busy  <= (w_next_state == ST_ISSUE_DATA) ||
                       (w_next_state == ST_ISSUE_NULL) ||
                       (w_next_state == ST_WAIT_SUM);
            r_done  <= w_done_set;
        end
    end

    // Sticky fault flags.
    always_ff @(posedge clk) begin
        if (init) begin
            r_timeout  <= 1'b0;
            r_rail_err <= 1'b0;
        end else begin
            r_timeout  <= r_timeout  | w_to_set;
            r_rail_err <= r_rail_err | w_re_set;
        end
    end

    // Per-digit acknowledge: follows DATA/NULL, holds on an illegal digit.
    always_ff @(posedge clk) begin
        if (init) begin
            r_sum_comp <= '0;
        end else if (w_next_state == ST_FAULT) begin
            r_sum_comp <= '0;
        end else begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (w_dig_data[k]) begin
                    r_sum_comp[k] <= 1'b1;
                end else if (w_dig_null[k]) begin
                    r_sum_comp[k] <= 1'b0;
                end else begin
                    r_sum_comp[k] <= r_sum_comp[k];
                end
            end
        end
    end

    // Wave collector: one capture per DATA wave, rearmed by the NULL wave.
    always_ff @(posedge clk) begin
        if (init) begin
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_armed       <= 1'b1;
        end else if ((r_state == ST_FAULT) || (w_next_state == ST_FAULT)) begin
            r_value       <= r_value;
            r_value_valid <= 1'b0;
            r_armed       <= r_armed;
        end else if (w_capture) begin
            r_value       <= w_rail1;
            r_value_valid <= 1'b1;
            r_armed       <= 1'b0;
        end else if (w_rearm) begin
            r_value       <= r_value;
            r_value_valid <= 1'b0;
            r_armed       <= 1'b1;
        end else begin
            r_value       <= r_value;
            r_value_valid <= 1'b0;
            r_armed       <= r_armed;
        end
    end

    // Remembers a rearm that lands before WAIT_SUM is reached.
    always_ff @(posedge clk) begin
        if (init) begin
            r_wave_done <= 1'b0;
        end else if (w_load || w_dec) begin
            r_wave_done <= 1'b0;
        end else if (w_active && w_rearm) begin
            r_wave_done <= 1'b1;
        end else begin
            r_wave_done <= r_wave_done;
        end
    end

    assign bus.cin_d       = r_cin_d;
    assign bus.sum_comp    = r_sum_comp;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.value       = r_value;
    assign bus.value_valid = r_value_valid;
    assign bus.timeout     = r_timeout;
    assign bus.rail_err    = r_rail_err;

endmodule

// File: tb/tb_ncl_counter_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ncl_counter_sequencer
// Bench for ncl_counter_sequencer with a behavioural dual-rail counter ring.
// Expected counts are queued when a run is started; a negedge monitor pops
// and compares on every value_valid pulse and counts done pulses.
// ----------------------------------------------------------------------------
module tb_ncl_counter_sequencer;
    localparam int N  = 32;
    localparam int SW = 16;
    localparam int SS = 2;
    localparam int TO = 1023;

    logic clk  = 1'b0;
    logic init = 1'b1;
    always #5 clk = ~clk;

    ncl_counter_sequencer_if #(.N_DIGITS(N), .STEP_W(SW)) bus ();

    ncl_counter_sequencer #(
        .N_DIGITS(N), .STEP_W(SW), .SYNC_STAGES(SS), .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int vv_cnt   = 0;
    int done_cnt = 0;
    logic [31:0] exp_q [$];

    // ring model state
    logic [31:0] ring_cnt    = 32'h0;
    logic [31:0] ring_preset = 32'h0;
    logic [63:0] ring_sum    = 64'h0;
    logic [63:0] inj         = 64'h0;
    int          ring_phase  = 0;
    int          ring_acc    = 0;
    int          data_limit  = 1000000;
    bit          hold_sum    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] encode(input logic [31:0] v);
        logic [63:0] e;
        e = 64'h0;
        for (int k = 0; k < 32; k++) begin
            e[2*k +: 2] = v[k] ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    // Behavioural ring: DATA in -> count+1 on the sums and ack; NULL in ->
    // drop ack; sums return to NULL once every digit has been acknowledged.
    initial begin
        bus.cin_comp = 1'b0;
        bus.sum_d    = 64'h0;
        forever begin
            @(posedge clk); #1;
            if (init) begin
                ring_cnt     = ring_preset;
                ring_phase   = 0;
                ring_acc     = 0;
                ring_sum     = 64'h0;
                bus.cin_comp = 1'b0;
            end else begin
                case (ring_phase)
                    0: if (bus.cin_d == 2'b10 && bus.sum_comp == 32'h0 && ring_acc < data_limit) begin
                        ring_cnt     = ring_cnt + 32'd1;
                        ring_acc     = ring_acc + 1;
                        bus.cin_comp = 1'b1;
                        ring_sum     = encode(ring_cnt);
                        ring_phase   = 1;
                    end
                    1: if (bus.cin_d == 2'b00) begin
                        bus.cin_comp = 1'b0;
                        ring_phase   = 2;
                    end
                    2: if (bus.sum_comp == 32'hFFFF_FFFF && !hold_sum) begin
                        ring_sum   = 64'h0;
                        ring_phase = 0;
                    end
                    default: ring_phase = 0;
                endcase
            end
            bus.sum_d = ring_sum | inj;
        end
    end

    // Monitor: scoreboard compare on value_valid, count done pulses.
    always @(negedge clk) begin
        if (bus.value_valid) begin
            vv_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL value_unexpected: got 0x%0h expected no value_valid", bus.value);
            end else begin
                check("value", {32'h0, bus.value}, {32'h0, exp_q.pop_front()});
            end
        end
        if (bus.done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic do_init();
        init = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        init = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cin_d"},       {62'h0, bus.cin_d},      64'h0);
        check({tag, "_sum_comp"},    {32'h0, bus.sum_comp},   64'h0);
        check({tag, "_busy"},        {63'h0, bus.busy},       64'h0);
        check({tag, "_done"},        {63'h0, bus.done},       64'h0);
        check({tag, "_value"},       {32'h0, bus.value},      64'h0);
        check({tag, "_value_valid"}, {63'h0, bus.value_valid},64'h0);
        check({tag, "_timeout"},     {63'h0, bus.timeout},    64'h0);
        check({tag, "_rail_err"},    {63'h0, bus.rail_err},   64'h0);
    endtask

    task automatic pulse_start(input logic [15:0] s);
        bus.steps = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int i = 0; i < 4000; i++) begin
            smp();
            if (done_cnt > base) break;
        end
        n_checks++;
        if (done_cnt <= base) begin
            n_fail++;
            $display("FAIL %s: done_count=%0d required>%0d within budget", tag, done_cnt, base);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time limit reached, required completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        int d0;
        int v0;
        int stuck;
        bit saw;
        bus.start = 1'b0;
        bus.steps = 16'h0;

        // reset state
        do_init();
        smp();
        check_reset("reset");

        // five increments from zero
        for (int v = 1; v <= 5; v++) exp_q.push_back(32'(v));
        d0 = done_cnt;
        pulse_start(16'd5);
        smp();
        check("run5_busy_rise", {63'h0, bus.busy}, 64'h1);
        wait_done("run5_done", d0);
        repeat (3) smp();
        check("run5_busy_low", {63'h0, bus.busy}, 64'h0);
        check("run5_done_count", 64'(done_cnt - d0), 64'h1);
        check("run5_queue_empty", 64'(exp_q.size()), 64'h0);
        check("run5_value", {32'h0, bus.value}, 64'h5);

        // zero steps: immediate done, no activity
        d0 = done_cnt;
        v0 = vv_cnt;
        pulse_start(16'd0);
        smp();
        check("zero_done_pulse", {63'h0, bus.done}, 64'h1);
        check("zero_busy", {63'h0, bus.busy}, 64'h0);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (bus.cin_d != 2'b00) saw = 1'b1;
            if (i == 0) check("zero_done_one_cycle", {63'h0, bus.done}, 64'h0);
        end
        check("zero_cin_idle", {63'h0, saw}, 64'h0);
        check("zero_no_valid", 64'(vv_cnt - v0), 64'h0);
        check("zero_done_count", 64'(done_cnt - d0), 64'h1);

        // wrap through 2^32
        ring_preset = 32'hFFFF_FFFE;
        do_init();
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        d0 = done_cnt;
        pulse_start(16'd3);
        wait_done("wrap_done", d0);
        repeat (3) smp();
        check("wrap_value", {32'h0, bus.value}, 64'h1);
        check("wrap_queue_empty", 64'(exp_q.size()), 64'h0);
        check("wrap_busy_low", {63'h0, bus.busy}, 64'h0);

        // stalled stage-0 ack -> watchdog fault
        ring_preset = 32'h0;
        data_limit  = 1;
        do_init();
        exp_q.push_back(32'h1);
        d0 = done_cnt;
        pulse_start(16'd3);
        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            smp();
            if (bus.timeout) break;
            if (bus.cin_d == 2'b10) stuck++;
            else stuck = 0;
        end
        check("wd_timeout", {63'h0, bus.timeout}, 64'h1);
        n_checks++;
        if (!(stuck >= TO && stuck <= TO + 3)) begin
            n_fail++;
            $display("FAIL wd_latency: got %0d cycles in DATA expected %0d..%0d", stuck, TO, TO + 3);
        end
        check("wd_cin_null", {62'h0, bus.cin_d}, 64'h0);
        check("wd_busy", {63'h0, bus.busy}, 64'h0);
        check("wd_sum_comp", {32'h0, bus.sum_comp}, 64'h0);
        check("wd_rail_err", {63'h0, bus.rail_err}, 64'h0);
        check("wd_no_done", 64'(done_cnt - d0), 64'h0);
        check("wd_first_wave", 64'(exp_q.size()), 64'h0);
        data_limit = 1000000;
        do_init();
        smp();
        check_reset("wd_clear");

        // illegal digit 7 while waiting for the sum NULL wave
        hold_sum = 1'b1;
        exp_q.push_back(32'h1);
        pulse_start(16'd2);
        for (int i = 0; i < 200; i++) begin
            smp();
            if (ring_phase == 2) break;
        end
        repeat (4) smp();
        inj = 64'h0000_0000_0000_C000;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (bus.rail_err) break;
        end
        check("rail_err_set", {63'h0, bus.rail_err}, 64'h1);
        check("rail_busy", {63'h0, bus.busy}, 64'h0);
        check("rail_cin_null", {62'h0, bus.cin_d}, 64'h0);
        check("rail_sum_comp", {32'h0, bus.sum_comp}, 64'h0);
        check("rail_timeout", {63'h0, bus.timeout}, 64'h0);
        check("rail_first_wave", 64'(exp_q.size()), 64'h0);
        pulse_start(16'd1);
        smp();
        check("rail_fault_holds", {63'h0, bus.busy}, 64'h0);
        check("rail_sticky", {63'h0, bus.rail_err}, 64'h1);
        inj      = 64'h0;
        hold_sum = 1'b0;
        do_init();
        smp();
        check_reset("rail_clear");

        // init in the middle of a ten-step run, then a clean two-step run
        for (int v = 1; v <= 10; v++) exp_q.push_back(32'(v));
        d0 = done_cnt;
        v0 = vv_cnt;
        pulse_start(16'd10);
        for (int i = 0; i < 2000; i++) begin
            smp();
            if (vv_cnt >= v0 + 4) break;
        end
        check("mid_progress", 64'(vv_cnt - v0 >= 4), 64'h1);
        init = 1'b1;
        exp_q.delete();
        smp();
        check_reset("mid_init");
        repeat (2) tick();
        init = 1'b0;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        pulse_start(16'd2);
        wait_done("after_init_done", d0);
        repeat (3) smp();
        check("after_init_value", {32'h0, bus.value}, 64'h2);
        check("after_init_busy", {63'h0, bus.busy}, 64'h0);
        check("after_init_queue", 64'(exp_q.size()), 64'h0);
        check("after_init_done_count", 64'(done_cnt - d0), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
